// File: rtl/uart_pkg.sv
// Shared constants and entry layout for the UART receive word path.
package uart_pkg;

  localparam logic [7:0]  ERR_FILL_DEF = 8'hEE;
  localparam int unsigned DEF_WORD_W   = 16;

  // Queue entry layout at the default geometry; err sits above the word.
  typedef struct packed {
    logic                  err;
    logic [DEF_WORD_W-1:0] word;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head is valid whenever not empty, zero when empty.
module sync_fifo #(
  parameter  int unsigned WIDTH = 17,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot on the same edge, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_word_buffer.sv
// Assembles WORDS received characters into one word, substitutes error words,
// and queues results in a show-ahead FIFO with sticky error/overflow status.
module uart_rx_word_buffer
  import uart_pkg::*;
#(
  parameter  int unsigned        DATA_W   = 8,
  parameter  int unsigned        WORDS    = 2,
  parameter  int unsigned        DEPTH    = 4,
  parameter  logic [DATA_W-1:0]  ERR_FILL = DATA_W'(ERR_FILL_DEF),
  localparam int unsigned        WORD_W   = DATA_W * WORDS,
  localparam int unsigned        CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  input  logic              PERROR,
  input  logic              FERROR,
  input  logic              out_ready,
  input  logic              clear_err,
  output logic [WORD_W-1:0] out,
  output logic              out_valid,
  output logic              out_err,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              perr_sticky,
  output logic              ferr_sticky
);

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] word;
  } entry_t;

  logic              char_err;
  logic              last_char;
  logic              push_req;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] assembled;
  entry_t            push_entry;
  entry_t            head_entry;

  assign char_err        = PERROR || FERROR;
  assign push_req        = valid && (char_err || last_char);
  assign push_entry.err  = char_err;
  assign push_entry.word = char_err ? {WORDS{ERR_FILL}} : assembled;
  assign pop             = out_valid && out_ready;

  generate
    if (WORDS > 1) begin : g_assemble
      localparam int unsigned PART_W = DATA_W * (WORDS - 1);
      localparam int unsigned IDX_W  = $clog2(WORDS);
      logic [PART_W-1:0] partial;
      logic [IDX_W-1:0]  idx;

      assign last_char = (idx == IDX_W'(WORDS - 1));
      assign assembled = {partial, data_in};

      // An errored character abandons the partial word as well as itself.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          partial <= '0;
          idx     <= '0;
        end else if (valid) begin
          if (char_err || last_char) begin
            partial <= '0;
            idx     <= '0;
          end else begin
            partial <= PART_W'({partial, data_in});
            idx     <= idx + IDX_W'(1);
          end
        end
      end
    end else begin : g_single
      assign last_char = 1'b1;
      assign assembled = data_in;
    end
  endgenerate

  sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (reset),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  assign out       = head_entry.word;
  assign out_err   = head_entry.err;
  assign out_valid = !fifo_empty;

  // Setting events take priority over clear_err in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      perr_sticky <= 1'b0;
      ferr_sticky <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      else if (clear_err)                overflow <= 1'b0;
      if (valid && PERROR)               perr_sticky <= 1'b1;
      else if (clear_err)                perr_sticky <= 1'b0;
      if (valid && FERROR)               ferr_sticky <= 1'b1;
      else if (clear_err)                ferr_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_word_buffer.sv
// Bench for uart_rx_word_buffer at DATA_W=8, WORDS=2, DEPTH=4: vector table,
// directed corner sequences and random traffic against a queue-based model.
module tb_uart_rx_word_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = '0;
  logic        valid = 1'b0;
  logic        PERROR = 1'b0;
  logic        FERROR = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic        out_err;
  logic [2:0]  count;
  logic        overflow;
  logic        perr_sticky;
  logic        ferr_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] m_q[$];
  logic [7:0]  m_chars[$];
  logic        m_ov = 1'b0;
  logic        m_pe = 1'b0;
  logic        m_fe = 1'b0;

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          pe;
    bit          fe;
    bit          rdy;
    logic [15:0] e_out;
    bit          e_val;
    bit          e_err;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[9];

  uart_rx_word_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid       (valid),
    .PERROR      (PERROR),
    .FERROR      (FERROR),
    .out_ready   (out_ready),
    .clear_err   (clear_err),
    .out         (out),
    .out_valid   (out_valid),
    .out_err     (out_err),
    .count       (count),
    .overflow    (overflow),
    .perr_sticky (perr_sticky),
    .ferr_sticky (ferr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_chars.delete();
    m_ov = 1'b0;
    m_pe = 1'b0;
    m_fe = 1'b0;
  endtask

  // Word-level model: characters collect in a list, two make a word, any error
  // replaces the word-in-progress with EEEE; queue holds at most four entries.
  task automatic model_step(input bit v, input logic [7:0] d, input bit pe, input bit fe,
                            input bit rdy, input bit clr);
    bit          do_pop;
    bit          do_push;
    bit          ov_set;
    logic [16:0] item;
    do_pop  = (m_q.size() != 0) && rdy;
    do_push = 1'b0;
    ov_set  = 1'b0;
    item    = '0;
    if (v) begin
      if (pe || fe) begin
        m_chars.delete();
        item    = {1'b1, 16'hEEEE};
        do_push = 1'b1;
      end else begin
        m_chars.push_back(d);
        if (m_chars.size() == 2) begin
          item = {1'b0, m_chars[0], m_chars[1]};
          m_chars.delete();
          do_push = 1'b1;
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < 4) m_q.push_back(item);
      else ov_set = 1'b1;
    end
    m_ov = ov_set      ? 1'b1 : (clr ? 1'b0 : m_ov);
    m_pe = (v && pe)   ? 1'b1 : (clr ? 1'b0 : m_pe);
    m_fe = (v && fe)   ? 1'b1 : (clr ? 1'b0 : m_fe);
  endtask

  task automatic compare_model(input string tag);
    logic [16:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 17'h0;
    check({tag, ".out"},       32'(out),         32'(h[15:0]));
    check({tag, ".out_err"},   32'(out_err),     32'(h[16]));
    check({tag, ".out_valid"}, 32'(out_valid),   32'(m_q.size() != 0));
    check({tag, ".count"},     32'(count),       32'(m_q.size()));
    check({tag, ".overflow"},  32'(overflow),    32'(m_ov));
    check({tag, ".perr"},      32'(perr_sticky), 32'(m_pe));
    check({tag, ".ferr"},      32'(ferr_sticky), 32'(m_fe));
  endtask

  task automatic apply(input bit v, input logic [7:0] d, input bit pe, input bit fe,
                       input bit rdy, input bit clr, input string tag);
    @(negedge clk);
    valid = v; data_in = d; PERROR = pe; FERROR = fe; out_ready = rdy; clear_err = clr;
    @(posedge clk);
    model_step(v, d, pe, fe, rdy, clr);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0; PERROR = 1'b0; FERROR = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    #1;
    check({tag, ".rst_out"}, 32'({out, out_valid, out_err, count}), 32'd0);
    check({tag, ".rst_flags"}, 32'({overflow, perr_sticky, ferr_sticky}), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 16'h4DE3, 1'b1, 1'b0, 3'd1};
    vecs[2] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 16'h4DE3, 1'b1, 1'b0, 3'd1};
    vecs[3] = '{1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 16'h4DE3, 1'b1, 1'b0, 3'd2};
    vecs[4] = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 16'h4DE3, 1'b1, 1'b0, 3'd2};
    vecs[5] = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 16'h4DE3, 1'b1, 1'b0, 3'd3};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'hEEEE, 1'b1, 1'b1, 3'd2};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b0, 3'd1};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 3'd0};

    // Clean word, then an errored word in the stream, then draining.
    do_reset("init");
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].v, vecs[i].d, vecs[i].pe, vecs[i].fe, vecs[i].rdy, 1'b0,
            $sformatf("vec%0d", i));
      check($sformatf("vec%0d.t_out", i), 32'(out),       32'(vecs[i].e_out));
      check($sformatf("vec%0d.t_val", i), 32'(out_valid), 32'(vecs[i].e_val));
      check($sformatf("vec%0d.t_err", i), 32'(out_err),   32'(vecs[i].e_err));
      check($sformatf("vec%0d.t_cnt", i), 32'(count),     32'(vecs[i].e_cnt));
    end
    check("vec.perr_sticky", 32'(perr_sticky), 32'd1);
    check("vec.ferr_sticky", 32'(ferr_sticky), 32'd0);

    // Overflow on the fifth word, then ordered drain.
    do_reset("ovf");
    for (int k = 1; k <= 5; k++) begin
      apply(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, "ovf_fill");
      apply(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, "ovf_fill");
    end
    check("ovf.count", 32'(count), 32'd4);
    check("ovf.flag",  32'(overflow), 32'd1);
    check("ovf.head",  32'(out), 32'h0101);
    for (int k = 2; k <= 4; k++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_drain");
      check($sformatf("ovf.drain%0d", k), 32'(out), 32'({8'(k), 8'(k)}));
    end
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_last");
    check("ovf.empty", 32'(out_valid), 32'd0);

    // Push and pop on the same edge while full.
    do_reset("full");
    for (int k = 1; k <= 4; k++) begin
      apply(1'b1, 8'(k * 17), 1'b0, 1'b0, 1'b0, 1'b0, "full_fill");
      apply(1'b1, 8'(k * 17), 1'b0, 1'b0, 1'b0, 1'b0, "full_fill");
    end
    apply(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "full_a5");
    apply(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, "full_pp");
    check("full.count", 32'(count), 32'd4);
    check("full.ovf",   32'(overflow), 32'd0);
    check("full.head",  32'(out), 32'h2222);
    for (int k = 0; k < 3; k++) apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "full_drain");
    check("full.tail",  32'(out), 32'hA5A5);
    check("full.tcnt",  32'(count), 32'd1);

    // Reset mid-word discards the pending byte.
    do_reset("mid");
    apply(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0, "mid_ab");
    do_reset("mid2");
    apply(1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b0, "mid_cd");
    apply(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, "mid_ef");
    check("mid.word",  32'(out), 32'hCDEF);
    check("mid.count", 32'(count), 32'd1);

    // clear_err loses to a simultaneous set, wins on its own.
    apply(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, "clr_set");
    check("clr.set_wins", 32'(ferr_sticky), 32'd1);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "clr_only");
    check("clr.cleared", 32'(ferr_sticky), 32'd0);

    // Random traffic with occasional resets.
    do_reset("rnd");
    for (int c = 0; c < 600; c++) begin
      if (c % 151 == 150) do_reset("rnd_rst");
      apply($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            ((c / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 15) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
